// File: rtl/color_cycle_pwm.sv
// color_cycle_pwm: three-channel RGB LED driver. A slow step tick walks the
// hue around six ramp sectors (mode 00) or breathes the brightness as a
// triangle wave (mode 01). Mode 10/11 freezes the colour. Each channel is
// rendered by a free-running PWM whose duty is latched only at the period
// boundary, so a duty change never produces a runt pulse.
module color_cycle_pwm #(
  parameter int PWM_INTERVAL = 1200,
  parameter int STEPS        = 100,
  parameter int TICK_DIV     = 20000,
  parameter int ACTIVE_LOW   = 1,
  localparam int DW          = $clog2(PWM_INTERVAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic [1:0]    rate_sel,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic          pwm_r,
  output logic          pwm_g,
  output logic          pwm_b
);

  localparam int FULL       = PWM_INTERVAL - 1;
  localparam int STEP_VALUE = PWM_INTERVAL / STEPS;
  localparam int CW         = $clog2(TICK_DIV + 1);
  localparam int RW         = $clog2(STEPS);
  localparam int LW         = $clog2(STEPS + 1);
  localparam int PW         = DW + LW;

  localparam logic [DW-1:0] FULL_V     = DW'(FULL);
  localparam logic [DW-1:0] PC_LAST    = DW'(PWM_INTERVAL - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(STEPS - 1);
  localparam logic [LW-1:0] LVL_MAX    = LW'(STEPS);
  localparam logic [CW-1:0] DIV_V      = CW'(TICK_DIV);
  localparam logic          POL        = (ACTIVE_LOW != 0);

  // Ramp value for a given number of steps; computed at 32 bits, truncated.
  function automatic logic [DW-1:0] ramp(input logic [31:0] n);
    logic [31:0] p;
    p = n * 32'(STEP_VALUE);
    return p[DW-1:0];
  endfunction

  // Brightness scaling: floor(base * lvl / STEPS); the product is DW+LW wide
  // so base*STEPS cannot overflow, and lvl == STEPS returns base exactly.
  function automatic logic [DW-1:0] scale(input logic [DW-1:0] base,
                                          input logic [LW-1:0] lvl_in);
    logic [PW-1:0] p;
    p = PW'(base) * PW'(lvl_in);
    p = p / PW'(STEPS);
    return p[DW-1:0];
  endfunction

  // Step timer
  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;
  logic          tick;

  // Hue and brightness state
  logic [2:0]    sector;
  logic [RW-1:0] round;
  logic [LW-1:0] lvl;
  logic          lvl_up;

  // Combinational colour
  logic [DW-1:0] up_v;
  logic [DW-1:0] dn_v;
  logic [DW-1:0] base_r;
  logic [DW-1:0] base_g;
  logic [DW-1:0] base_b;

  // PWM engine
  logic [DW-1:0] pc;
  logic [DW-1:0] dl_r;
  logic [DW-1:0] dl_g;
  logic [DW-1:0] dl_b;
  logic          raw_r;
  logic          raw_g;
  logic          raw_b;

  // Compare with >= rather than == so that shrinking LIMIT mid-count
  // (rate_sel raised) still fires a tick immediately instead of waiting
  // for the counter to wrap through its full width.
  assign limit = DIV_V >> rate_sel;
  assign tick  = (cnt >= limit - CW'(1));

  // Step counter: counts 0..LIMIT-1 and restarts on the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Hue walk: only mode 00 advances round/sector; every other mode holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sector <= 3'd0;
      round  <= '0;
    end else if (mode == 2'b00 && tick) begin
      if (round == ROUND_LAST) begin
        round  <= '0;
        sector <= (sector == 3'd5) ? 3'd0 : sector + 3'd1;
      end else begin
        round <= round + RW'(1);
      end
    end
  end

  // Brightness: pinned to full/down in mode 00, triangle walk in mode 01,
  // held in freeze modes. Direction flips on reaching either end so lvl
  // never leaves 0..STEPS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl    <= LVL_MAX;
      lvl_up <= 1'b0;
    end else begin
      case (mode)
        2'b00: begin
          lvl    <= LVL_MAX;
          lvl_up <= 1'b0;
        end
        2'b01: begin
          if (tick) begin
            if (lvl_up) begin
              if (lvl < LVL_MAX) begin
                lvl <= lvl + LW'(1);
                if (lvl == LVL_MAX - LW'(1)) lvl_up <= 1'b0;
              end else begin
                lvl_up <= 1'b0;
              end
            end else begin
              if (lvl > '0) begin
                lvl <= lvl - LW'(1);
                if (lvl == LW'(1)) lvl_up <= 1'b1;
              end else begin
                lvl_up <= 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign up_v = ramp(32'(round));
  assign dn_v = ramp(32'(STEPS - 1) - 32'(round));

  // Base colour per sector, straight from the registered hue state.
  always_comb begin
    base_r = FULL_V;
    base_g = up_v;
    base_b = '0;
    case (sector)
      3'd1: begin base_r = dn_v;   base_g = FULL_V; base_b = '0;     end
      3'd2: begin base_r = '0;     base_g = FULL_V; base_b = up_v;   end
      3'd3: begin base_r = '0;     base_g = dn_v;   base_b = FULL_V; end
      3'd4: begin base_r = up_v;   base_g = '0;     base_b = FULL_V; end
      3'd5: begin base_r = FULL_V; base_g = '0;     base_b = dn_v;   end
      default: begin
      end
    endcase
  end

  assign duty_r = scale(base_r, lvl);
  assign duty_g = scale(base_g, lvl);
  assign duty_b = scale(base_b, lvl);

  // PWM period counter, free running regardless of mode or tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (pc == PC_LAST) begin
      pc <= '0;
    end else begin
      pc <= pc + DW'(1);
    end
  end

  // Duty latch: sampled only on the last count of a period. A tick in the
  // same cycle has not yet updated the hue state, so the pre-tick duty wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_r <= FULL_V;
      dl_g <= '0;
      dl_b <= '0;
    end else if (pc == PC_LAST) begin
      dl_r <= duty_r;
      dl_g <= duty_g;
      dl_b <= duty_b;
    end
  end

  // Registered comparator outputs keep the pins free of decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_r <= 1'b0;
      raw_g <= 1'b0;
      raw_b <= 1'b0;
    end else begin
      raw_r <= (pc < dl_r);
      raw_g <= (pc < dl_g);
      raw_b <= (pc < dl_b);
    end
  end

  assign pwm_r = raw_r ^ POL;
  assign pwm_g = raw_g ^ POL;
  assign pwm_b = raw_b ^ POL;

endmodule

// File: doc/color_cycle_pwm.md
COLOR_CYCLE_PWM -- requirements
Module: color_cycle_pwm

Interface
REQ-001 Parameter PWM_INTERVAL, default 1200, PWM period in clocks; DW = $clog2(PWM_INTERVAL); FULL = PWM_INTERVAL-1.
REQ-002 Parameter STEPS, default 100, ramp steps per hue sector, at least 2; STEP_VALUE = PWM_INTERVAL/STEPS (integer).
REQ-003 Parameter TICK_DIV, default 20000, base clocks per ramp step, at least 8.
REQ-004 Parameter ACTIVE_LOW, default 1; 1 inverts the pwm_* pins for common-anode LEDs.
REQ-005 clk  input  1  system clock, 12 MHz.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 mode  input  2  00 hue cycle, 01 breathe, 10 freeze, 11 treated as freeze.
REQ-008 rate_sel  input  2  step interval LIMIT = TICK_DIV >> rate_sel.
REQ-009 duty_r, duty_g, duty_b  output  DW each  current duty per channel, range 0..FULL.
REQ-010 pwm_r, pwm_g, pwm_b  output  1 each  PWM pin per channel.

Function
REQ-011 Step counter shall count 0..LIMIT-1; tick shall be a one-cycle strobe when count >= LIMIT-1, and the counter shall return to 0 on the tick.
REQ-012 A rate_sel change mid-count shall not stall: if count >= new LIMIT-1, tick on the next cycle.
REQ-013 Hue state: sector (0..5) and round (0..STEPS-1); in mode 00 each tick increments round; round STEPS-1 wraps to 0 and advances sector; sector 5 wraps to 0.
REQ-014 UP = round*STEP_VALUE; DN = (STEPS-1-round)*STEP_VALUE; computed at 32 bits, truncated to DW.
REQ-015 Base duty (R,G,B) by sector: 0 (FULL,UP,0); 1 (DN,FULL,0); 2 (0,FULL,UP); 3 (0,DN,FULL); 4 (UP,0,FULL); 5 (FULL,0,DN).
REQ-016 Base duty shall be combinational from the registered sector/round, with no one-step lag.
REQ-017 Brightness level lvl shall range 0..STEPS, plus a direction bit; in mode 00, lvl shall be forced to STEPS with direction down.
REQ-018 In mode 01, hue state shall be frozen.
REQ-019 In mode 01, each tick moves lvl one step in its direction; at 0 the direction turns up, at STEPS it turns down, so the wave is a triangle.
REQ-020 In mode 01, lvl shall never go outside 0..STEPS.
REQ-021 duty_x = (base_x * lvl) / STEPS, integer floor; the intermediate product shall be wide enough that it does not overflow; lvl = STEPS gives exactly base_x.
REQ-022 In modes 10 and 11, the tick shall still run, but hue, lvl and direction shall hold, so duty_* is constant.
REQ-023 On a mode change, state shall carry over; entering 01 from 00 starts at lvl = STEPS going down; returning to 00 restores full brightness on the next cycle.
REQ-024 PWM counter pc shall run 0..PWM_INTERVAL-1 and wrap, independent of mode and tick.
REQ-025 Latched duties dl_x shall load duty_x only in the cycle pc = PWM_INTERVAL-1, so the duty changes only at a period boundary (glitch-free).
REQ-026 Raw pin = (pc < dl_x); it shall be registered, and pwm_x = raw XOR ACTIVE_LOW.
REQ-027 Duty 0 shall give a raw pin that is never high; duty FULL shall give a raw pin high for FULL of PWM_INTERVAL clocks.
REQ-028 A tick and a pc wrap in the same cycle shall latch the pre-tick duty; the new duty takes effect one period later.

Reset
REQ-029 While rst_n = 0, all registers shall clear asynchronously: step counter 0, sector 0, round 0, lvl STEPS, direction down, pc 0, dl_r = FULL, dl_g = dl_b = 0.
REQ-030 While in reset, duty_r = FULL, duty_g = duty_b = 0.
REQ-031 While in reset, the raw pins shall be 0, so pwm_x = ACTIVE_LOW (LED off).
REQ-032 Deassertion may be asynchronous to clk; the first count shall occur on the first clk rising edge after rst_n goes high.
REQ-033 Reset asserted mid-operation shall restore all REQ-029 to REQ-031 values immediately, with no clock needed.

Verification
REQ-034 Bench parameters shall be PWM_INTERVAL=12, STEPS=4, TICK_DIV=8, ACTIVE_LOW=0, giving STEP_VALUE=3 and FULL=11.
REQ-035 Mode 00, rate_sel 0, release reset -> duty_g = 0,3,6,9 at ticks 0..3, tick period 8 clocks; then sector 1 gives duty_r = 9,6,3,0 with duty_g = 11; after 24 ticks the state is back at (11,0,0).
REQ-036 rate_sel = 2 -> LIMIT 2, one tick every 2 clocks; switching 0->2 when count = 5 -> tick on the next cycle.
REQ-037 Mode 01 at sector 0, round 2 (base 11,6,0) -> lvl sequence 4,3,2,1,0,1,2..., duty_g = 6,4,3,1,0,1,3; hue registers unchanged.
REQ-038 duty_g = 6 held for one period -> pwm_g high exactly 6 of 12 clocks; a duty change mid-period is not visible until pc wraps.
REQ-039 Mode 10 for 50 ticks -> duties constant; then reset asserted mid-period -> outputs take reset values within the same cycle; ACTIVE_LOW=1 run -> pins inverted.
